sr_sipo_rx: RTL and testbench



---
 rtl/sr_sipo_rx_if.sv | 35 +++
 rtl/sr_sipo_rx.sv | 92 +++++++++
 tb/tb_sr_sipo_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sr_sipo_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : sr_sipo_rx_if
//  Brief    : Serial input, frame sync and word-output handshake bundle
//             for the sr_sipo_rx deserializer.
//  Revision : 1.0 - initial release
// ============================================================================
interface sr_sipo_rx_if #(
    parameter int WIDTH = 8
);
    localparam int c_cnt_w = $clog2(WIDTH);

    logic               sin;
    logic               sin_en;
    logic               sync;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [c_cnt_w-1:0] bit_cnt;
    logic               overrun;
    logic               overrun_clr;

    // master: the link/consumer side driving bits and taking words
    modport master (
        output sin, sin_en, sync, dout_ready, overrun_clr,
        input  dout, dout_valid, bit_cnt, overrun
    );

    // slave: the receiver itself
    modport slave (
        input  sin, sin_en, sync, dout_ready, overrun_clr,
        output dout, dout_valid, bit_cnt, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sr_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sr_sipo_rx
//  Brief    : Serial-in/parallel-out receiver with bit counter, frame sync,
//             one-entry valid/ready output buffer and sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_sipo_rx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  wire          clk,
    input  wire          reset,
    sr_sipo_rx_if.slave  bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [WIDTH-1:0]   r_sh;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_sh_base;
    logic [WIDTH-1:0]   w_sh_shifted;
    logic [WIDTH-1:0]   w_sh_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_complete;
    logic               w_pop;
    logic               w_drop;

    // Sync clears the partial word before any bit sampled in the same cycle
    assign w_sh_base = bus.sync ? '0 : r_sh;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_sh_shifted = (w_sh_base >> 1) | (WIDTH'(bus.sin) << (WIDTH - 1));
        end else begin : g_msb_first
            assign w_sh_shifted = (w_sh_base << 1) | WIDTH'(bus.sin);
        end
    endgenerate

    assign w_complete = bus.sin_en && !bus.sync && (r_bit_cnt == c_last);
    assign w_pop      = r_dout_valid && bus.dout_ready;
    assign w_drop     = w_complete && r_dout_valid && !bus.dout_ready;

    always_comb begin
        w_sh_next  = r_sh;
        w_cnt_next = r_bit_cnt;
        if (bus.sync) begin
            w_sh_next  = bus.sin_en ? w_sh_shifted : '0;
            w_cnt_next = bus.sin_en ? c_cnt_w'(1) : '0;
        end else if (bus.sin_en) begin
            w_sh_next  = w_sh_shifted;
            w_cnt_next = w_complete ? '0 : r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh         <= '0;
            r_bit_cnt    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sh      <= w_sh_next;
            r_bit_cnt <= w_cnt_next;

            // A word lands when the buffer is empty or is emptied this cycle
            if (w_complete && (!r_dout_valid || bus.dout_ready)) begin
                r_dout       <= w_sh_shifted;
                r_dout_valid <= 1'b1;
            end else if (w_pop) begin
                r_dout_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_sr_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_sipo_rx
//  Brief    : Directed self-checking bench; one LSB-first and one MSB-first
//             receiver share the same serial stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_sipo_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'b0, sin_en = 1'b0, sync = 1'b0, dout_ready = 1'b0, overrun_clr = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sr_sipo_rx_if #(.WIDTH(8)) bus_l ();
    sr_sipo_rx_if #(.WIDTH(8)) bus_m ();

    assign bus_l.sin = sin;          assign bus_m.sin = sin;
    assign bus_l.sin_en = sin_en;    assign bus_m.sin_en = sin_en;
    assign bus_l.sync = sync;        assign bus_m.sync = sync;
    assign bus_l.dout_ready = dout_ready;   assign bus_m.dout_ready = dout_ready;
    assign bus_l.overrun_clr = overrun_clr; assign bus_m.overrun_clr = overrun_clr;

    sr_sipo_rx #(.WIDTH(8), .LSB_FIRST(1)) dut_l (.clk(clk), .reset(rst), .bus(bus_l));
    sr_sipo_rx #(.WIDTH(8), .LSB_FIRST(0)) dut_m (.clk(clk), .reset(rst), .bus(bus_m));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin_en = 1'b1;
        sin    = b;
        step();
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    // Sends w[0] first; LSB-first receiver rebuilds w, MSB-first builds rev8(w)
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic chk_word(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_m,
                            input logic exp_v);
        chk({tag, "_dout_l"}, 32'(bus_l.dout), 32'(exp_l));
        chk({tag, "_dout_m"}, 32'(bus_m.dout), 32'(exp_m));
        chk({tag, "_valid_l"}, 32'(bus_l.dout_valid), 32'(exp_v));
        chk({tag, "_valid_m"}, 32'(bus_m.dout_valid), 32'(exp_v));
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] c3c;
        int         gaps [8];

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk_word("reset", 8'h00, 8'h00, 1'b0);
        chk("reset_cnt", 32'(bus_l.bit_cnt), 0);
        chk("reset_ovr", 32'(bus_l.overrun), 0);

        // 0xA5: symmetric, same result for both bit orders; exact latency
        dout_ready = 1'b1;
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("a5_cnt", 32'(bus_l.bit_cnt), 32'(i));
            chk("a5_novalid", 32'(bus_l.dout_valid), 0);
            send_bit(a5[i]);
        end
        chk_word("a5", 8'hA5, 8'hA5, 1'b1);
        chk("a5_cnt_wrap", 32'(bus_m.bit_cnt), 0);
        step();
        chk_word("a5_pop", 8'hA5, 8'hA5, 1'b0);

        // Stream 0,0,0,1,0,0,1,0: MSB-first 0x12, LSB-first 0x48
        send_word(8'h48);
        chk_word("s12", 8'h48, 8'h12, 1'b1);
        step();

        // Irregular gaps carrying 0x3C; count must hold while idle
        c3c  = 8'h3C;
        gaps = '{0, 2, 1, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                step();
                chk("gap_cnt_hold", 32'(bus_l.bit_cnt), 32'(i));
            end
            send_bit(c3c[i]);
        end
        chk_word("x3c", 8'h3C, 8'h3C, 1'b1);
        step();
        chk_word("x3c_pop", 8'h3C, 8'h3C, 1'b0);

        // Overrun: consumer stalled, second word dropped
        dout_ready = 1'b0;
        send_word(8'h11);
        chk_word("ov_11", 8'h11, rev8(8'h11), 1'b1);
        send_word(8'h22);
        chk_word("ov_22_drop", 8'h11, rev8(8'h11), 1'b1);
        chk("ov_set_l", 32'(bus_l.overrun), 1);
        chk("ov_set_m", 32'(bus_m.overrun), 1);
        step();
        chk("ov_sticky", 32'(bus_l.overrun), 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ov_clr", 32'(bus_l.overrun), 0);

        // Pop coincides with 0x33 completion: no loss, no overrun
        for (int i = 0; i < 7; i++) send_bit(1'(8'h33 >> i));
        dout_ready = 1'b1;
        send_bit(1'b0);
        chk_word("pop_same", 8'h33, rev8(8'h33), 1'b1);
        chk("pop_same_ovr", 32'(bus_l.overrun), 0);
        step();
        chk_word("pop_33", 8'h33, rev8(8'h33), 1'b0);

        // Drop and clear in the same cycle: set wins
        dout_ready = 1'b0;
        send_word(8'h5A);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        overrun_clr = 1'b1;
        send_bit(1'b1);
        overrun_clr = 1'b0;
        chk("ov_set_wins", 32'(bus_l.overrun), 1);
        chk_word("ov_set_dout", 8'h5A, rev8(8'h5A), 1'b1);
        dout_ready = 1'b1;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ov_clr2", 32'(bus_l.overrun), 0);

        // Sync mid-word with a bit on the same cycle, then rest of 0x81
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("sync_pre_cnt", 32'(bus_l.bit_cnt), 5);
        sync = 1'b1;
        send_bit(1'b1);
        sync = 1'b0;
        chk("sync_cnt", 32'(bus_l.bit_cnt), 1);
        chk_word("sync_noeffect", 8'h5A, rev8(8'h5A), 1'b0);
        for (int i = 1; i < 8; i++) send_bit(1'(8'h81 >> i));
        chk_word("sync_81", 8'h81, 8'h81, 1'b1);
        step();

        // Reset mid-word, then a clean 0xF0
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        sin_en = 1'b1;
        sin = 1'b1;
        step();
        rst = 1'b0;
        sin_en = 1'b0;
        sin = 1'b0;
        chk_word("rst_mid", 8'h00, 8'h00, 1'b0);
        chk("rst_mid_cnt", 32'(bus_l.bit_cnt), 0);
        send_word(8'hF0);
        chk_word("f0", 8'hF0, 8'h0F, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
